pc_predict_unit: RTL and testbench
==================================

Name: pc_predict_unit

Overview:
Parametrised next-generation program-counter block for the fetch stage. It holds the PC register and predicts PC-relative conditional branches at fetch using a bimodal table of 2-bit saturating counters. It resolves branches in EX from the flag register and redirects the PC with a flush on mispredict. It replaces the purely combinational next-PC logic and adds stall, sticky halt, prediction, recovery and a mispredict counter.

Parameters:
PC_W, 16, PC and address width in bits.
IMM_W, 9, branch immediate width; sign-extended to PC_W, then shifted left by 1.
IDX_W, 4, predictor index bits; the table has 2^IDX_W entries.
CNT_W, 16, mispredict counter width.
RESET_PC, 0, PC value loaded on reset.

Ports:
clk  in  1  clock; all state updates on the rising edge.
rst  in  1  synchronous reset, active-high.
stall  in  1  hold the PC (hazard or memory wait).
halt  in  1  HLT decoded at fetch; freezes the PC permanently until reset.
if_is_br  in  1  fetched instruction is a conditional branch.
if_cond  in  3  condition code of the fetched branch.
if_imm  in  IMM_W  immediate of the fetched branch.
ex_br_valid  in  1  a branch is resolving in EX this cycle.
ex_cond  in  3  condition code of the resolving branch.
ex_imm  in  IMM_W  immediate of the resolving branch.
ex_pc  in  PC_W  address of the resolving branch.
ex_pred_taken  in  1  prediction made for that branch at fetch, carried down the pipe.
flags  in  3  {N,Z,V}: N=flags[2], Z=flags[1], V=flags[0].
pc  out  PC_W  current fetch address (registered).
pred_taken  out  1  combinational prediction for the current fetch.
flush  out  1  combinational; kills the IF/ID stages this cycle.
halted  out  1  registered sticky halt state.
mispred_cnt  out  CNT_W  saturating count of mispredicts.

Behaviour:
- Reset values: pc=RESET_PC, halted=0, mispred_cnt=0, all counters=2'b01 (weakly not-taken).
- Outputs while rst=1: flush=0 and pred_taken=0.
- Condition evaluation (cond_true), for both fetch and EX:
  - 000 NE: Z=0.
  - 001 EQ: Z=1.
  - 010 GT: Z=0 and N=0.
  - 011 LT: N=1.
  - 100 GE: Z=1 or (Z=0 and N=0).
  - 101 LE: N=1 or Z=1.
  - 110 OV: V=1.
  - 111 UNC: always true.
- Targets:
  - seq(x) = x+2.
  - tgt(x,imm) = x+2+(sext(imm)<<1).
  - All arithmetic is modulo 2^PC_W and wraps silently.
- Table index is addr[IDX_W:1].
- Prediction:
  - pred_taken = if_is_br & (if_cond==111 | ctr[idx(pc)][1]).
  - pred_taken is 0 when halted=1 or stall=1.
- Resolution (only when ex_br_valid=1):
  - actual = cond_true(ex_cond, flags).
  - mispredict = actual XOR ex_pred_taken.
  - flush = mispredict.
- Next-PC priority at each edge:
  1. rst.
  2. mispredict: load actual ? tgt(ex_pc,ex_imm) : seq(ex_pc). This overrides stall, halt and halted; a redirect while halted=1 does not clear halted.
  3. halted=1 or stall=1: hold.
  4. halt=1: hold the PC and set halted.
  5. pred_taken: load tgt(pc,if_imm).
  6. Otherwise: load seq(pc).
- Halt during a mispredict: the halt is discarded because it came from the wrong path, and halted stays unchanged.
- Counter update (when ex_br_valid=1, regardless of stall):
  - ctr[idx(ex_pc)] increments saturating at 11 if actual, else decrements saturating at 00.
  - cond 111 also updates.
  - A same-cycle fetch read of the same index sees the pre-update value; the write lands at the edge.
- mispred_cnt increments by 1 per mispredict cycle and saturates at all-ones.
- Single-cycle latency: the redirect PC is visible on pc the cycle after flush.
- Reset asserted mid-operation: all state returns to reset values at that edge regardless of other inputs.

Test Plan:
- Reset/sequential: hold rst 2 cycles, then idle → pc=0,2,4,6; pred_taken=0; halted=0; mispred_cnt=0.
- Stall then halt:
  - Stall at pc=0x0008 for 3 cycles → pc holds 0x0008, then resumes 0x000A.
  - Assert halt at pc=0x0010 → pc frozen at 0x0010 and halted=1 for ≥5 cycles, even after halt deasserts.
- Cold mispredict and redirect: EX branch ex_pc=0x0020, ex_cond=001, Z=1, ex_imm=9'h004, ex_pred_taken=0 → flush=1 that cycle; next pc=0x002A; mispred_cnt=1; ctr[0]=10.
- Trained prediction: repeat the same taken branch once more → ctr saturates at 11. Then fetch if_is_br=1 at pc=0x0020, if_cond=001, if_imm=9'h1FE (−2) → pred_taken=1; next pc=0x001E.
- Condition sweep: all 8 codes × flag combos 000, 010, 100, 001 → actual matches the table above. Specifically GE with N=1,Z=0 → not taken; OV with V=1 → taken.
- Boundaries:
  - Taken branch at pc=0xFFFE, imm=0 → wraps to 0x0000.
  - Mispredict while stall=1 and halted=1 → pc still redirects; halted stays 1.
  - Force mispred_cnt to 0xFFFF, then mispredict → stays 0xFFFF.
  - rst asserted mid-redirect → pc=RESET_PC and counters back to 01.

Source files
------------

// File: rtl/pc_predict_if.sv
// pc_predict_if: fetch/EX branch signals and PC outputs of the next-PC unit.
interface pc_predict_if #(
   parameter int PC_W  = 16,
   parameter int IMM_W = 9,
   parameter int CNT_W = 16
);
   logic             stall;
   logic             halt;
   logic             if_is_br;
   logic [2:0]       if_cond;
   logic [IMM_W-1:0] if_imm;
   logic             ex_br_valid;
   logic [2:0]       ex_cond;
   logic [IMM_W-1:0] ex_imm;
   logic [PC_W-1:0]  ex_pc;
   logic             ex_pred_taken;
   logic [2:0]       flags;
   logic [PC_W-1:0]  pc;
   logic             pred_taken;
   logic             flush;
   logic             halted;
   logic [CNT_W-1:0] mispred_cnt;
   modport master (
      output stall, halt, if_is_br, if_cond, if_imm, ex_br_valid, ex_cond, ex_imm, ex_pc,
             ex_pred_taken, flags,
      input  pc, pred_taken, flush, halted, mispred_cnt
   );
   modport slave (
      input  stall, halt, if_is_br, if_cond, if_imm, ex_br_valid, ex_cond, ex_imm, ex_pc,
             ex_pred_taken, flags,
      output pc, pred_taken, flush, halted, mispred_cnt
   );
endinterface

// File: rtl/pc_predict_unit.sv
// pc_predict_unit: fetch PC register with bimodal branch prediction and EX-stage mispredict recovery.
module pc_predict_unit #(
   parameter int              PC_W     = 16,
   parameter int              IMM_W    = 9,
   parameter int              IDX_W    = 4,
   parameter int              CNT_W    = 16,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input logic         clk,
   input logic         rst,
   pc_predict_if.slave bus
);
   logic [1:0]       ctr [2**IDX_W];
   logic [PC_W-1:0]  pc_q;
   logic             halted_q;
   logic [CNT_W-1:0] cnt_q;
   logic             actual;
   logic             mispred;
   logic             pred;
   logic [IDX_W-1:0] ex_idx;

   function automatic logic cond_true(input logic [2:0] c, input logic [2:0] f);
      logic n, z, v;
      {n, z, v} = f;
      case (c)
         3'b000:  return !z;
         3'b001:  return z;
         3'b010:  return !z && !n;
         3'b011:  return n;
         3'b100:  return z || !n;
         3'b101:  return n || z;
         3'b110:  return v;
         default: return 1'b1;
      endcase
   endfunction

   function automatic logic [PC_W-1:0] tgt(input logic [PC_W-1:0] x, input logic [IMM_W-1:0] imm);
      return x + PC_W'(2) + ({{(PC_W-IMM_W){imm[IMM_W-1]}}, imm} << 1);
   endfunction

   assign ex_idx  = bus.ex_pc[IDX_W:1];
   assign actual  = cond_true(bus.ex_cond, bus.flags);
   assign mispred = !rst && bus.ex_br_valid && (actual != bus.ex_pred_taken);
   // Fetch reads the pre-update counter; an EX write to the same entry lands at the edge.
   assign pred    = !rst && !halted_q && !bus.stall && bus.if_is_br &&
                    (bus.if_cond == 3'b111 || ctr[pc_q[IDX_W:1]][1]);

   assign bus.pc          = pc_q;
   assign bus.pred_taken  = pred;
   assign bus.flush       = mispred;
   assign bus.halted      = halted_q;
   assign bus.mispred_cnt = cnt_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         pc_q     <= RESET_PC;
         halted_q <= 1'b0;
         cnt_q    <= '0;
         for (int i = 0; i < 2**IDX_W; i++) ctr[i] <= 2'b01;
      end else begin
         // A redirect beats stall and halt; a halt on the wrong path is dropped.
         pc_q     <= mispred ? (actual ? tgt(bus.ex_pc, bus.ex_imm) : bus.ex_pc + PC_W'(2)) :
                     (halted_q || bus.stall || bus.halt) ? pc_q :
                     pred ? tgt(pc_q, bus.if_imm) : pc_q + PC_W'(2);
         halted_q <= halted_q || (!mispred && !bus.stall && bus.halt);
         if (mispred && cnt_q != '1) cnt_q <= cnt_q + CNT_W'(1);
         if (bus.ex_br_valid)
            ctr[ex_idx] <= actual ? (ctr[ex_idx] == 2'b11 ? 2'b11 : ctr[ex_idx] + 2'd1) :
                                    (ctr[ex_idx] == 2'b00 ? 2'b00 : ctr[ex_idx] - 2'd1);
      end
   end
endmodule

// File: tb/tb_pc_predict_unit.sv
// tb_pc_predict_unit: directed vectors with a queue-based scoreboard for pc_predict_unit.
module tb_pc_predict_unit;
   typedef struct {
      logic [15:0] pc;
      logic        pred;
      logic        flush;
      logic        halted;
      logic [15:0] cnt;
      logic [2:0]  cs;
   } exp_t;

   logic        clk;
   logic        rst;
   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          m = 0;
   logic [15:0] p;
   logic        act;
   logic [7:0]  tbl [4] = '{8'h95, 8'hB2, 8'hA9, 8'hD5};
   logic [2:0]  fv  [4] = '{3'b000, 3'b010, 3'b100, 3'b001};

   pc_predict_if #(.PC_W(16), .IMM_W(9), .CNT_W(16)) b ();
   pc_predict_if #(.PC_W(16), .IMM_W(9), .CNT_W(3))  b2 ();

   pc_predict_unit #(.PC_W(16), .IMM_W(9), .IDX_W(4), .CNT_W(16), .RESET_PC(16'h0000)) dut (
      .clk(clk), .rst(rst), .bus(b));
   // Narrow counter copy lets saturation be reached in a few mispredicts.
   pc_predict_unit #(.PC_W(16), .IMM_W(9), .IDX_W(4), .CNT_W(3), .RESET_PC(16'h0000)) dut_s (
      .clk(clk), .rst(rst), .bus(b2));

   assign b2.stall         = b.stall;
   assign b2.halt          = b.halt;
   assign b2.if_is_br      = b.if_is_br;
   assign b2.if_cond       = b.if_cond;
   assign b2.if_imm        = b.if_imm;
   assign b2.ex_br_valid   = b.ex_br_valid;
   assign b2.ex_cond       = b.ex_cond;
   assign b2.ex_imm        = b.ex_imm;
   assign b2.ex_pc         = b.ex_pc;
   assign b2.ex_pred_taken = b.ex_pred_taken;
   assign b2.flags         = b.flags;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      if (q.size() > 0) begin
         exp_t e;
         e = q.pop_front();
         chk("pc", 32'(b.pc), 32'(e.pc));
         chk("pred_taken", 32'(b.pred_taken), 32'(e.pred));
         chk("flush", 32'(b.flush), 32'(e.flush));
         chk("halted", 32'(b.halted), 32'(e.halted));
         chk("mispred_cnt", 32'(b.mispred_cnt), 32'(e.cnt));
         chk("mispred_cnt_sat", 32'(b2.mispred_cnt), 32'(e.cs));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic clr();
      rst = 1'b0;
      b.stall = 1'b0; b.halt = 1'b0;
      b.if_is_br = 1'b0; b.if_cond = 3'd0; b.if_imm = 9'd0;
      b.ex_br_valid = 1'b0; b.ex_cond = 3'd0; b.ex_imm = 9'd0; b.ex_pc = 16'd0;
      b.ex_pred_taken = 1'b0; b.flags = 3'd0;
   endtask

   task automatic ex(input logic [15:0] pc, input logic [2:0] c, input logic [8:0] imm,
                     input logic [2:0] f, input logic pt);
      b.ex_br_valid = 1'b1; b.ex_pc = pc; b.ex_cond = c; b.ex_imm = imm;
      b.flags = f; b.ex_pred_taken = pt;
   endtask

   task automatic push(input logic [15:0] pc, input logic pred, input logic fl, input logic h);
      exp_t e;
      e.pc = pc; e.pred = pred; e.flush = fl; e.halted = h;
      e.cnt = 16'(m); e.cs = m > 7 ? 3'd7 : 3'(m);
      q.push_back(e);
   endtask

   initial begin
      clr();
      rst = 1'b1;
      @(posedge clk);
      tick(); rst = 1'b1; b.if_is_br = 1'b1; b.if_cond = 3'd7; ex(16'h0030, 3'd7, 9'd0, 3'd0, 1'b0);
      push(16'h0000, 0, 0, 0);
      tick(); clr(); push(16'h0000, 0, 0, 0);
      tick(); clr(); push(16'h0002, 0, 0, 0);
      tick(); clr(); push(16'h0004, 0, 0, 0);
      tick(); clr(); push(16'h0006, 0, 0, 0);
      repeat (3) begin tick(); clr(); b.stall = 1'b1; push(16'h0008, 0, 0, 0); end
      tick(); clr(); push(16'h0008, 0, 0, 0);
      tick(); clr(); push(16'h000A, 0, 0, 0);
      tick(); clr(); push(16'h000C, 0, 0, 0);
      tick(); clr(); push(16'h000E, 0, 0, 0);
      tick(); clr(); b.halt = 1'b1; push(16'h0010, 0, 0, 0);
      repeat (5) begin tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd7; push(16'h0010, 0, 0, 1); end
      // redirect while stalled and halted
      tick(); clr(); b.stall = 1'b1; ex(16'h0042, 3'd7, 9'd0, 3'd0, 1'b0); push(16'h0010, 0, 1, 1); m++;
      tick(); clr(); push(16'h0044, 0, 0, 1);
      tick(); clr(); rst = 1'b1; push(16'h0044, 0, 0, 1); m = 0;
      // cold mispredict: EQ with Z=1, predicted not-taken
      tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd1; ex(16'h0020, 3'd1, 9'h004, 3'b010, 1'b0);
      push(16'h0000, 0, 1, 0); m++;
      tick(); clr(); ex(16'h0020, 3'd1, 9'h004, 3'b010, 1'b1); push(16'h002A, 0, 0, 0);
      tick(); clr(); ex(16'h001E, 3'd0, 9'h000, 3'b010, 1'b1); push(16'h002C, 0, 1, 0); m++;
      tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd1; b.if_imm = 9'h1FE; push(16'h0020, 1, 0, 0);
      tick(); clr(); push(16'h001E, 0, 0, 0);
      // halt on the wrong path is dropped
      tick(); clr(); b.halt = 1'b1; ex(16'h0050, 3'd7, 9'd0, 3'd0, 1'b0); push(16'h0020, 0, 1, 0); m++;
      tick(); clr(); push(16'h0052, 0, 0, 0);
      p = 16'h0054;
      for (int fi = 0; fi < 4; fi++) begin
         for (int c = 0; c < 8; c++) begin
            tick(); clr(); b.stall = 1'b1;
            ex(16'h0106, 3'(c), 9'd0, fv[fi], 1'b0);
            act = tbl[fi][c];
            push(p, 0, act, 0);
            if (act) begin m++; p = 16'h0108; end
         end
      end
      // address wrap
      tick(); clr(); ex(16'hFFFC, 3'd7, 9'd0, 3'd0, 1'b0); push(p, 0, 1, 0); m++;
      tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd7; push(16'hFFFE, 1, 0, 0);
      tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd1; b.if_imm = 9'h004; push(16'h0000, 1, 0, 0);
      // reset during a redirect restores counters
      tick(); clr(); rst = 1'b1; b.if_is_br = 1'b1; b.if_cond = 3'd7; ex(16'h0060, 3'd7, 9'd0, 3'd0, 1'b0);
      push(16'h000A, 0, 0, 0); m = 0;
      tick(); clr(); b.if_is_br = 1'b1; b.if_cond = 3'd1; b.if_imm = 9'h004; push(16'h0000, 0, 0, 0);
      tick(); clr(); push(16'h0002, 0, 0, 0);
      repeat (3) @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
